// File: rtl/pulse_train_monitor.sv
// pulse_train_monitor
//   Receive-side checker for a pulse train on the loop-back path. An arm rising edge starts one
//   capture. The block then reports the arm-to-first-rise delay, the width of the last complete
//   pulse, the rise-to-rise period of the last two pulses and the rising-edge count.
//
// Optional feature: define PTM_CHECK_EN to compare the result against exp_period_i/exp_width_i
//   and drive err_mismatch_o. Without the macro err_mismatch_o is tied low.
//
// Ports
//   clk_500m_i      measurement clock, all logic on posedge
//   reset_i         synchronous active-high reset
//   arm_i           rising edge starts a capture (synchronous to clk_500m_i)
//   sig_in_i        asynchronous pulse train under test
//   cnt_nums_i      expected pulse count, 0 = capture until timeout
//   timeout_cyc_i   cycles without a rising edge that end the capture, 0 = no timeout
//   exp_period_i    expected period (PTM_CHECK_EN only)
//   exp_width_i     expected width (PTM_CHECK_EN only)
//   busy_o          capture in progress
//   meas_valid_o    one-cycle strobe, results stable from here until the next arm
//   meas_delay_o    arm to first rising edge, cycles
//   meas_width_o    high time of the last complete pulse, cycles
//   meas_period_o   rise to rise of the last two pulses, 0 if fewer than two
//   meas_count_o    rising edges seen, saturating at 255
//   err_timeout_o   capture ended by timeout before cnt_nums_i was reached
//   err_mismatch_o  period/width check failed

module pulse_train_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DLY_W       = 32,
  parameter int unsigned WID_W       = 16
) (
  input  logic             clk_500m_i,
  input  logic             reset_i,
  input  logic             arm_i,
  input  logic             sig_in_i,
  input  logic [7:0]       cnt_nums_i,
  input  logic [31:0]      timeout_cyc_i,
  input  logic [31:0]      exp_period_i,
  input  logic [15:0]      exp_width_i,
  output logic             busy_o,
  output logic             meas_valid_o,
  output logic [DLY_W-1:0] meas_delay_o,
  output logic [WID_W-1:0] meas_width_o,
  output logic [DLY_W-1:0] meas_period_o,
  output logic [7:0]       meas_count_o,
  output logic             err_timeout_o,
  output logic             err_mismatch_o
);

  typedef enum logic [2:0] {StIdle, StWait, StHigh, StLow, StDone} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sig_sync_q, arm_sync_q;
  logic                   sig_prev_q, arm_prev_q;
  logic [7:0]             cnt_nums_q;
  logic [31:0]            timeout_q;
  // Running counters hold the value for the current cycle: 1 in the first cycle after the
  // reference edge, so an edge seen k cycles later latches exactly k.
  logic [DLY_W-1:0]       dly_q, per_q;
  logic [WID_W-1:0]       wid_q;
  logic [31:0]            idle_q;
  logic                   meas_valid_q, err_timeout_q;
  logic [DLY_W-1:0]       meas_delay_q, meas_period_q;
  logic [WID_W-1:0]       meas_width_q;
  logic [7:0]             meas_count_q;

  logic sig_s, arm_s, sig_rise, sig_fall, arm_rise, arm_take, timeout_hit, cnt_done;

  // arm runs through the same depth as sig_in so synchronizer latency cancels in meas_delay
  assign sig_s       = sig_sync_q[SYNC_STAGES-1];
  assign arm_s       = arm_sync_q[SYNC_STAGES-1];
  assign sig_rise    = sig_s & ~sig_prev_q;
  assign sig_fall    = ~sig_s & sig_prev_q;
  assign arm_rise    = arm_s & ~arm_prev_q;
  assign arm_take    = (state_q == StIdle) && arm_rise;
  assign timeout_hit = (timeout_q != 32'd0) && (idle_q >= timeout_q);
  assign cnt_done    = (cnt_nums_q != 8'd0) && (meas_count_q == cnt_nums_q);

  always_ff @(posedge clk_500m_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      sig_sync_q    <= '0;
      arm_sync_q    <= '0;
      sig_prev_q    <= 1'b0;
      arm_prev_q    <= 1'b0;
      cnt_nums_q    <= 8'd0;
      timeout_q     <= 32'd0;
      dly_q         <= '0;
      per_q         <= '0;
      wid_q         <= '0;
      idle_q        <= 32'd0;
      meas_valid_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      meas_delay_q  <= '0;
      meas_period_q <= '0;
      meas_width_q  <= '0;
      meas_count_q  <= 8'd0;
    end else begin
      sig_sync_q   <= {sig_sync_q[SYNC_STAGES-2:0], sig_in_i};
      arm_sync_q   <= {arm_sync_q[SYNC_STAGES-2:0], arm_i};
      sig_prev_q   <= sig_s;
      arm_prev_q   <= arm_s;
      meas_valid_q <= 1'b0;

      // Free-running saturating counters; overridden below on edges
      if (dly_q != '1) dly_q <= dly_q + DLY_W'(1);
      if (per_q != '1) per_q <= per_q + DLY_W'(1);
      if (wid_q != '1) wid_q <= wid_q + WID_W'(1);
      if (idle_q != '1) idle_q <= idle_q + 32'd1;

      unique case (state_q)
        StIdle: begin
          if (arm_rise) begin
            cnt_nums_q    <= cnt_nums_i;
            timeout_q     <= timeout_cyc_i;
            dly_q         <= DLY_W'(1);
            per_q         <= DLY_W'(1);
            wid_q         <= WID_W'(1);
            idle_q        <= 32'd1;
            err_timeout_q <= 1'b0;
            meas_delay_q  <= '0;
            meas_period_q <= '0;
            meas_width_q  <= '0;
            // A rise coincident with the arm edge is the first pulse with zero delay
            meas_count_q  <= sig_rise ? 8'd1 : 8'd0;
            state_q       <= sig_rise ? StHigh : StWait;
          end
        end
        StWait: begin
          if (sig_rise) begin
            meas_delay_q <= dly_q;
            meas_count_q <= 8'd1;
            per_q        <= DLY_W'(1);
            wid_q        <= WID_W'(1);
            idle_q       <= 32'd1;
            state_q      <= StHigh;
          end else if (timeout_hit) begin
            meas_delay_q  <= dly_q;
            err_timeout_q <= (cnt_nums_q != 8'd0);
            meas_valid_q  <= 1'b1;
            state_q       <= StDone;
          end
        end
        StHigh: begin
          if (sig_fall) begin
            meas_width_q <= wid_q;
            if (cnt_done) begin
              meas_valid_q <= 1'b1;
              state_q      <= StDone;
            end else begin
              state_q <= StLow;
            end
          end else if (timeout_hit) begin
            // Pulse still high: its width is never reported
            err_timeout_q <= (cnt_nums_q != 8'd0);
            meas_valid_q  <= 1'b1;
            state_q       <= StDone;
          end
        end
        StLow: begin
          if (sig_rise) begin
            meas_period_q <= per_q;
            if (meas_count_q != 8'hff) meas_count_q <= meas_count_q + 8'd1;
            per_q   <= DLY_W'(1);
            wid_q   <= WID_W'(1);
            idle_q  <= 32'd1;
            state_q <= StHigh;
          end else if (timeout_hit) begin
            err_timeout_q <= (cnt_nums_q != 8'd0);
            meas_valid_q  <= 1'b1;
            state_q       <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = (state_q == StWait) || (state_q == StHigh) || (state_q == StLow);
  assign meas_valid_o  = meas_valid_q;
  assign meas_delay_o  = meas_delay_q;
  assign meas_width_o  = meas_width_q;
  assign meas_period_o = meas_period_q;
  assign meas_count_o  = meas_count_q;
  assign err_timeout_o = err_timeout_q;

`ifdef PTM_CHECK_EN
  logic [DLY_W-1:0] exp_period_q;
  logic [WID_W-1:0] exp_width_q;
  logic             res_seen_q;

  always_ff @(posedge clk_500m_i) begin
    if (reset_i) begin
      exp_period_q <= '0;
      exp_width_q  <= '0;
      res_seen_q   <= 1'b0;
    end else if (arm_take) begin
      exp_period_q <= DLY_W'(exp_period_i);
      exp_width_q  <= WID_W'(exp_width_i);
      res_seen_q   <= 1'b0;
    end else if (meas_valid_q) begin
      res_seen_q <= 1'b1;
    end
  end

  // Results are frozen from meas_valid until the next arm, so the compare can be combinational
  assign err_mismatch_o = (res_seen_q | meas_valid_q) &
                          (((meas_count_q >= 8'd2) && (meas_period_q != exp_period_q)) ||
                           (meas_width_q != exp_width_q));
`else
  logic unused_exp;
  logic unused_take;
  assign unused_exp     = ^{exp_period_i, exp_width_i};
  assign unused_take    = arm_take;
  assign err_mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_train_monitor.sv
module tb_pulse_train_monitor;

  localparam int LAT = 3;  // sync depth 2 plus edge detect, applied to arm and sig alike

  logic        clk = 1'b0;
  logic        reset, arm, sig;
  logic [7:0]  cnt_nums;
  logic [31:0] timeout_cyc, exp_period;
  logic [15:0] exp_width;
  logic        busy, meas_valid, err_timeout, err_mismatch;
  logic [31:0] meas_delay, meas_period;
  logic [15:0] meas_width;
  logic [7:0]  meas_count;

  pulse_train_monitor dut (
    .clk_500m_i    (clk),
    .reset_i       (reset),
    .arm_i         (arm),
    .sig_in_i      (sig),
    .cnt_nums_i    (cnt_nums),
    .timeout_cyc_i (timeout_cyc),
    .exp_period_i  (exp_period),
    .exp_width_i   (exp_width),
    .busy_o        (busy),
    .meas_valid_o  (meas_valid),
    .meas_delay_o  (meas_delay),
    .meas_width_o  (meas_width),
    .meas_period_o (meas_period),
    .meas_count_o  (meas_count),
    .err_timeout_o (err_timeout),
    .err_mismatch_o(err_mismatch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse list as raw offsets from the arm drive cycle
  int p_rise[$];
  int p_fall[$];

  function automatic logic level_at(input int k);
    foreach (p_rise[i]) if (k >= p_rise[i] && k < p_fall[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Walks the pulse list event by event: what the capture must report and when it ends
  task automatic model_run(input int cnt, input int tmo, output int d_done, output int e_delay,
                           output int e_width, output int e_period, output int e_count,
                           output int e_tout);
    int  ref_t = 0;
    int  i     = 0;
    bit  fin   = 0;
    e_delay = 0; e_width = 0; e_period = 0; e_count = 0; e_tout = 0; d_done = 0;
    while (!fin) begin
      if (i >= p_rise.size() || (tmo != 0 && p_rise[i] - ref_t > tmo)) begin
        if (e_count == 0) e_delay = tmo;
        d_done = ref_t + tmo;
        e_tout = (cnt != 0);
        fin    = 1;
      end else begin
        if (e_count == 0) e_delay = p_rise[i];
        else e_period = p_rise[i] - p_rise[i-1];
        if (e_count < 255) e_count++;
        ref_t = p_rise[i];
        if (tmo != 0 && p_fall[i] - p_rise[i] > tmo) begin
          d_done = ref_t + tmo;
          e_tout = (cnt != 0);
          fin    = 1;
        end else begin
          e_width = p_fall[i] - p_rise[i];
          if (cnt != 0 && e_count == cnt) begin
            d_done = p_fall[i];
            fin    = 1;
          end
        end
        i++;
      end
    end
  endtask

  // Expectations consumed by the compare process
  bit    mdl_on = 0;
  string m_tag;
  int    m_start, m_valid, m_delay, m_width, m_period, m_count, m_tout, m_mm;

  always @(negedge clk) begin
    if (mdl_on) begin
      check({m_tag, "/busy"}, busy, (cyc >= m_start) && (cyc < m_valid));
      check({m_tag, "/meas_valid"}, meas_valid, cyc == m_valid);
      if (cyc == m_valid) begin
        check({m_tag, "/delay"}, meas_delay, m_delay);
        check({m_tag, "/width"}, meas_width, m_width);
        check({m_tag, "/period"}, meas_period, m_period);
        check({m_tag, "/count"}, meas_count, m_count);
        check({m_tag, "/err_timeout"}, err_timeout, m_tout);
        check({m_tag, "/err_mismatch"}, err_mismatch, m_mm);
      end
    end
  end

  task automatic run(input string tag, input int cnt, input int tmo, input int n, input int d0,
                     input int w, input int per, input int last_w, input int glitch,
                     input int xp, input int xw, input int l_delay, input int l_width,
                     input int l_period, input int l_count, input int l_tout, input int l_done,
                     input int l_mm);
    int d_done, e_delay, e_width, e_period, e_count, e_tout, mm, n_a;
    p_rise.delete();
    p_fall.delete();
    for (int i = 0; i < n; i++) begin
      p_rise.push_back(d0 + i * per);
      p_fall.push_back(d0 + i * per + ((i == n - 1) ? last_w : w));
    end
    model_run(cnt, tmo, d_done, e_delay, e_width, e_period, e_count, e_tout);
    mm = ((e_count >= 2 && e_period != xp) || (e_width != xw)) ? 1 : 0;
`ifdef PTM_CHECK_EN
    check({tag, "/model_mismatch"}, mm, l_mm);
`else
    mm = l_mm & 0;
`endif
    // Hand-computed values pin the model itself
    check({tag, "/model_delay"}, e_delay, l_delay);
    check({tag, "/model_width"}, e_width, l_width);
    check({tag, "/model_period"}, e_period, l_period);
    check({tag, "/model_count"}, e_count, l_count);
    check({tag, "/model_tout"}, e_tout, l_tout);
    check({tag, "/model_done"}, d_done, l_done);

    cnt_nums = 8'(cnt); timeout_cyc = tmo; exp_period = xp; exp_width = 16'(xw);
    @(posedge clk); #1;
    arm = 1'b1;
    sig = level_at(0);
    n_a = cyc;
    m_tag = tag; m_start = n_a + LAT; m_valid = n_a + LAT + d_done;
    m_delay = e_delay; m_width = e_width; m_period = e_period; m_count = e_count;
    m_tout = e_tout; m_mm = mm;
    mdl_on = 1;
    for (int k = 1; k <= d_done + 8; k++) begin
      @(posedge clk); #1;
      arm = (k < 3) || (glitch != 0 && k >= glitch && k < glitch + 2);
      sig = level_at(k);
    end
    mdl_on = 0;
    @(negedge clk);
    check({tag, "/hold_count"}, meas_count, e_count);
    check({tag, "/hold_delay"}, meas_delay, e_delay);
    arm = 1'b0;
    sig = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; sig = 1'b0;
    cnt_nums = 8'd0; timeout_cyc = 32'd0; exp_period = 32'd0; exp_width = 16'd0;

    // Reset with the input toggling: everything quiet
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      sig = ~sig;
      arm = k[0];
      @(negedge clk);
      check("reset/outputs", {busy, meas_valid, err_timeout, err_mismatch, |meas_delay,
                              |meas_width, |meas_period, |meas_count}, 8'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0; arm = 1'b0; sig = 1'b0;
    repeat (5) @(posedge clk);

    //   tag            cnt tmo  n d0 w per lw gl  xp xw  dly w  per cnt to done mm
    run("nominal",       4, 1000, 4, 20, 5, 50,  5,  0, 50, 6, 20, 5, 50, 4, 0, 175, 1);
    run("check_ok",      4, 1000, 4, 20, 5, 50,  5,  0, 50, 5, 20, 5, 50, 4, 0, 175, 0);
    run("timeout",      10,  200, 3, 20, 5, 50,  5,  0,  0, 0, 20, 5, 50, 3, 1, 320, 1);
    run("no_pulse",      0,  100, 0,  0, 0,  0,  0,  0,  0, 0, 100, 0, 0, 0, 0, 100, 0);
    run("long_high",     0,  150, 3, 10, 8, 40, 400, 0,  0, 0, 10, 8, 40, 3, 0, 240, 1);
    run("coincident",    2,   50, 2,  0, 3, 10,  3,  0, 10, 3,  0, 3, 10, 2, 0,  13, 0);
    run("rearm_high",    4, 1000, 4, 20, 5, 50,  5, 21, 50, 5, 20, 5, 50, 4, 0, 175, 0);

    // Reset while the capture sits in LOW: abort, no strobe, outputs cleared
    cnt_nums = 8'd4; timeout_cyc = 32'd1000;
    @(posedge clk); #1;
    arm = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
      arm = (k < 3);
      sig = (k >= 20 && k < 25);
    end
    @(negedge clk);
    check("abort/busy_before", busy, 1'b1);
    check("abort/count_before", meas_count, 8'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      sig = ~sig;
    end
    reset = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(posedge clk); #1;
      sig = (k % 50) < 5;
      @(negedge clk);
      check("abort/quiet", {meas_valid, busy}, 2'b00);
    end
    check("abort/outputs", {err_timeout, err_mismatch, |meas_delay, |meas_width,
                            |meas_period, |meas_count}, 6'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
